// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead add/subtract datapath.
package cla_pkg;
  localparam int GRP = 4;

  function automatic int grp_count(input int width);
    return width / GRP;
  endfunction
endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead block: bit carries plus group propagate/generate.
module cla_group4 (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       ci_i,
  output logic [3:1] c_o,
  output logic       co_o,
  output logic       pg_o,
  output logic       gg_o
);
  assign c_o[1] = g_i[0] | (p_i[0] & ci_i);
  assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & ci_i);
  assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & ci_i);

  assign pg_o = &p_i;
  assign gg_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
              | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
  assign co_o = gg_o | (pg_o & ci_i);
endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined add/subtract on 4-bit group lookahead with a whole-pipe
// valid/ready stall (no skid buffer).
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int NG = grp_count(WIDTH);

  logic             s1_load, s2_load;
  logic             vld_p1_q, vld_p2_q;
  logic [WIDTH-1:0] bb_p0, p_p0, g_p0;
  logic             c0_p0;
  logic [NG-1:0]    pg_p0, gg_p0;
  logic [3*NG-1:0]  unused_c_p0;
  logic [NG-1:0]    unused_co_p0;
  logic [WIDTH-1:0] p_p1_q, g_p1_q;
  logic             c0_p1_q;
  logic [NG-1:0]    pg_p1_q, gg_p1_q;
  logic [NG:0]      c_grp_p1;
  logic [WIDTH-1:0] carry_p1;
  logic [NG-1:0]    unused_co_p1, unused_pg_p1, unused_gg_p1;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, ovf_d, zero_d;
  logic             cout_q, ovf_q, zero_q;

  assign s2_load  = !vld_p2_q | out_ready;
  assign s1_load  = !vld_p1_q | s2_load;
  assign in_ready = s1_load;

  // Stage 0 -> 1: operand conditioning and per-group propagate/generate
  assign bb_p0 = in_sub ? ~in_b : in_b;
  assign c0_p0 = in_sub | in_cin;
  assign p_p0  = in_a ^ bb_p0;
  assign g_p0  = in_a & bb_p0;

  for (genvar k = 0; k < NG; k++) begin : g_grp_p0
    cla_group4 u_grp (
      .g_i (g_p0[4*k +: 4]),
      .p_i (p_p0[4*k +: 4]),
      .ci_i(1'b0),
      .c_o (unused_c_p0[3*k +: 3]),
      .co_o(unused_co_p0[k]),
      .pg_o(pg_p0[k]),
      .gg_o(gg_p0[k])
    );
  end

  // Stage 1 -> 2: group carry chain, in-group carries, sum and flags
  assign c_grp_p1[0] = c0_p1_q;

  for (genvar k = 0; k < NG; k++) begin : g_grp_p1
    assign c_grp_p1[k+1]  = gg_p1_q[k] | (pg_p1_q[k] & c_grp_p1[k]);
    assign carry_p1[4*k]  = c_grp_p1[k];
    cla_group4 u_grp (
      .g_i (g_p1_q[4*k +: 4]),
      .p_i (p_p1_q[4*k +: 4]),
      .ci_i(c_grp_p1[k]),
      .c_o (carry_p1[4*k+1 +: 3]),
      .co_o(unused_co_p1[k]),
      .pg_o(unused_pg_p1[k]),
      .gg_o(unused_gg_p1[k])
    );
  end

  assign sum_d  = p_p1_q ^ carry_p1;
  assign cout_d = c_grp_p1[NG];
  assign ovf_d  = carry_p1[WIDTH-1] ^ cout_d;
  assign zero_d = ~|sum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      p_p1_q   <= '0;
      g_p1_q   <= '0;
      c0_p1_q  <= 1'b0;
      pg_p1_q  <= '0;
      gg_p1_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      if (s1_load) vld_p1_q <= in_valid;
      if (s2_load) vld_p2_q <= vld_p1_q;
      if (s1_load && in_valid) begin
        p_p1_q  <= p_p0;
        g_p1_q  <= g_p0;
        c0_p1_q <= c0_p0;
        pg_p1_q <= pg_p0;
        gg_p1_q <= gg_p0;
      end
      if (s2_load && vld_p1_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
endmodule
